// File: rtl/led_status_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_status_scheduler
// Brief    : Per-unit fault lifecycle FSMs with an arrival-order queue driving
//            three RGB status LEDs, plus an end-of-run green blink takeover.
// Revision : 1.0 - initial release
// ============================================================================
module led_status_scheduler #(
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       EU_fault_flag,
    input  logic       CU_fault_flag,
    input  logic       RU_fault_flag,
    input  logic       fault_detect,
    input  logic       object_drop,
    input  logic       run_complete,
    output logic       led1_R1,
    output logic       led1_G1,
    output logic       led1_B1,
    output logic       led2_R2,
    output logic       led2_G2,
    output logic       led2_B2,
    output logic       led3_R3,
    output logic       led3_G3,
    output logic       led3_B3,
    output logic [1:0] active_unit,
    output logic       orphan_event
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_DETECTED  = 2'd2,
        ST_RECTIFIED = 2'd3
    } unit_state_t;

    localparam int              CNT_W      = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [2:0]       r_prev_flags;
    logic             r_prev_fd, r_prev_od, r_prev_rc;
    unit_state_t      r_st   [3];
    unit_state_t      w_st_n [3];
    logic [1:0]       r_q    [3];
    logic [1:0]       w_q_n  [3];
    logic [1:0]       r_cnt, w_cnt_n;
    logic             r_run_done, r_phase_on;
    logic [CNT_W-1:0] r_blink;
    logic [2:0]       r_led  [3];
    logic             r_orphan;
    logic [1:0]       r_active;

    logic [2:0]  w_flags, w_flag_rise;
    logic        w_fd_rise, w_od_rise, w_rc_rise, w_freeze;
    logic        w_adv, w_pop, w_orphan_n;
    unit_state_t w_head_st;

    assign w_flags     = {RU_fault_flag, CU_fault_flag, EU_fault_flag};
    assign w_flag_rise = w_flags & ~r_prev_flags;
    assign w_fd_rise   = fault_detect & ~r_prev_fd;
    assign w_od_rise   = object_drop  & ~r_prev_od;
    assign w_rc_rise   = run_complete & ~r_prev_rc;
    assign w_freeze    = r_run_done | w_rc_rise;

    function automatic logic [2:0] f_rgb(input unit_state_t s);
        case (s)
            ST_ARMED:     f_rgb = 3'b100;
            ST_DETECTED:  f_rgb = 3'b001;
            ST_RECTIFIED: f_rgb = 3'b010;
            default:      f_rgb = 3'b000;
        endcase
    endfunction

    always_comb begin
        case (r_q[0])
            2'd1:    w_head_st = r_st[0];
            2'd2:    w_head_st = r_st[1];
            2'd3:    w_head_st = r_st[2];
            default: w_head_st = ST_IDLE;
        endcase
    end

    // A detect rise shadows a same-cycle drop rise entirely, including its orphan pulse.
    assign w_adv      = !w_freeze && w_fd_rise && (r_cnt != 2'd0) && (w_head_st == ST_ARMED);
    assign w_pop      = !w_freeze && !w_fd_rise && w_od_rise && (r_cnt != 2'd0)
                        && (w_head_st == ST_DETECTED);
    assign w_orphan_n = !w_freeze && ((w_fd_rise && (r_cnt == 2'd0))
                        || (!w_fd_rise && w_od_rise && !w_pop));

    // Pop is applied first so pushes land behind the surviving entries.
    always_comb begin
        w_q_n   = r_q;
        w_cnt_n = r_cnt;
        w_st_n  = r_st;
        if (w_pop) begin
            w_q_n[0] = r_q[1];
            w_q_n[1] = r_q[2];
            w_q_n[2] = 2'd0;
            w_cnt_n  = r_cnt - 2'd1;
        end
        for (int u = 0; u < 3; u++) begin
            if (w_adv && (r_q[0] == 2'(u + 1)))
                w_st_n[u] = ST_DETECTED;
            if (w_pop && (r_q[0] == 2'(u + 1)))
                w_st_n[u] = ST_RECTIFIED;
            if (!w_freeze && w_flag_rise[u] && (r_st[u] == ST_IDLE)) begin
                w_st_n[u] = ST_ARMED;
                if (w_cnt_n != 2'd3)
                    w_q_n[w_cnt_n] = 2'(u + 1);
                w_cnt_n = w_cnt_n + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_prev_flags <= 3'b000;
            r_prev_fd    <= 1'b0;
            r_prev_od    <= 1'b0;
            r_prev_rc    <= 1'b0;
            for (int u = 0; u < 3; u++) begin
                r_st[u]  <= ST_IDLE;
                r_q[u]   <= 2'd0;
                r_led[u] <= 3'b000;
            end
            r_cnt      <= 2'd0;
            r_run_done <= 1'b0;
            r_phase_on <= 1'b1;
            r_blink    <= '0;
            r_orphan   <= 1'b0;
            r_active   <= 2'd0;
        end else begin
            r_prev_flags <= w_flags;
            r_prev_fd    <= fault_detect;
            r_prev_od    <= object_drop;
            r_prev_rc    <= run_complete;
            r_st         <= w_st_n;
            r_q          <= w_q_n;
            r_cnt        <= w_cnt_n;
            r_orphan     <= w_orphan_n;

            if (!r_run_done && w_rc_rise) begin
                r_run_done <= 1'b1;
                r_phase_on <= 1'b1;
                r_blink    <= '0;
            end else if (r_run_done) begin
                if (r_blink == C_CNT_LAST) begin
                    r_blink    <= '0;
                    r_phase_on <= ~r_phase_on;
                end else begin
                    r_blink <= r_blink + 1'b1;
                end
            end

            for (int u = 0; u < 3; u++)
                r_led[u] <= r_run_done ? (r_phase_on ? 3'b010 : 3'b000) : f_rgb(r_st[u]);
            r_active <= (r_cnt != 2'd0) ? r_q[0] : 2'd0;
        end
    end

    assign {led1_R1, led1_G1, led1_B1} = r_led[0];
    assign {led2_R2, led2_G2, led2_B2} = r_led[1];
    assign {led3_R3, led3_G3, led3_B3} = r_led[2];
    assign active_unit  = r_active;
    assign orphan_event = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_led_status_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_status_scheduler
// Brief    : Directed self-checking bench for led_status_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_scheduler;

    localparam int BC = 4;
    // stim bit map: 0 EU, 1 CU, 2 RU, 3 fault_detect, 4 object_drop, 5 run_complete
    localparam logic [6:0] C_EU = 7'b0000001;
    localparam logic [6:0] C_CU = 7'b0000010;
    localparam logic [6:0] C_RU = 7'b0000100;
    localparam logic [6:0] C_FD = 7'b0001000;
    localparam logic [6:0] C_OD = 7'b0010000;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic [6:0] stim    = 7'b0;
    logic       l1r, l1g, l1b, l2r, l2g, l2b, l3r, l3g, l3b;
    logic [1:0] active_unit;
    logic       orphan_event;
    logic       orph_k;
    int         checks   = 0;
    int         failures = 0;

    led_status_scheduler #(.BLINK_CYCLES(BC)) dut (
        .clk_50M       (clk_50M),
        .reset         (reset),
        .EU_fault_flag (stim[0]),
        .CU_fault_flag (stim[1]),
        .RU_fault_flag (stim[2]),
        .fault_detect  (stim[3]),
        .object_drop   (stim[4]),
        .run_complete  (stim[5]),
        .led1_R1 (l1r), .led1_G1 (l1g), .led1_B1 (l1b),
        .led2_R2 (l2r), .led2_G2 (l2g), .led2_B2 (l2b),
        .led3_R3 (l3r), .led3_G3 (l3g), .led3_B3 (l3b),
        .active_unit   (active_unit),
        .orphan_event  (orphan_event)
    );

    always #5 clk_50M = ~clk_50M;

    function automatic logic [2:0] led(input int u);
        case (u)
            0:       led = {l1r, l1g, l1b};
            1:       led = {l2r, l2g, l2b};
            default: led = {l3r, l3g, l3b};
        endcase
    endfunction

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    // Raise the masked inputs for one edge (state changes there), drop them and
    // step once more so LEDs reflect the new state; orph_k holds the pulse slot.
    task automatic pulse(input logic [6:0] m);
        stim = stim | m;
        step();
        orph_k = orphan_event;
        stim = stim & ~m;
        step();
        checks++;
        if (orphan_event !== 1'b0) begin
            failures++;
            $display("FAIL orphan_width got=%b want=0", orphan_event);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({led(0), led(1), led(2)} !== 9'b0 || active_unit !== 2'd0 || orphan_event !== 1'b0) begin
            failures++;
            $display("FAIL %s leds=%b au=%0d orph=%b want all 0", name,
                     {led(0), led(1), led(2)}, active_unit, orphan_event);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset_state");
    endtask

    task automatic test_single_lifecycle();
        logic [2:0] exp_led [3];
        logic [1:0] exp_au  [3];
        logic [6:0] seq     [3];
        exp_led = '{3'b100, 3'b001, 3'b010};
        exp_au  = '{2'd1, 2'd1, 2'd0};
        seq     = '{C_EU, C_FD, C_OD};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse(seq[i]);
            checks++;
            if (led(0) !== exp_led[i] || active_unit !== exp_au[i] || orph_k !== 1'b0
                || led(1) !== 3'b000 || led(2) !== 3'b000) begin
                failures++;
                $display("FAIL single_step%0d led1=%b au=%0d orph=%b led2=%b led3=%b want led1=%b au=%0d orph=0 others 000",
                         i, led(0), active_unit, orph_k, led(1), led(2), exp_led[i], exp_au[i]);
            end
        end
    endtask

    task automatic test_simultaneous_arming();
        do_reset();
        pulse(C_EU | C_CU | C_RU);
        checks++;
        if (active_unit !== 2'd1 || {led(0), led(1), led(2)} !== 9'b100_100_100) begin
            failures++;
            $display("FAIL simul_arm au=%0d leds=%b want au=1 leds=100100100",
                     active_unit, {led(0), led(1), led(2)});
        end
        for (int u = 0; u < 3; u++) begin
            pulse(C_FD);
            checks++;
            if (led(u) !== 3'b001 || active_unit !== 2'(u + 1)) begin
                failures++;
                $display("FAIL simul_detect u=%0d led=%b au=%0d want led=001 au=%0d",
                         u, led(u), active_unit, u + 1);
            end
            pulse(C_OD);
            checks++;
            if (led(u) !== 3'b010 || active_unit !== ((u < 2) ? 2'(u + 2) : 2'd0)) begin
                failures++;
                $display("FAIL simul_drop u=%0d led=%b au=%0d want led=010 au=%0d",
                         u, led(u), active_unit, (u < 2) ? u + 2 : 0);
            end
        end
    endtask

    task automatic test_orphans();
        do_reset();
        pulse(C_OD);
        checks++;
        if (orph_k !== 1'b1) begin
            failures++;
            $display("FAIL orphan_empty got=%b want=1", orph_k);
        end
        pulse(C_CU);
        pulse(C_OD);
        checks++;
        if (orph_k !== 1'b1 || led(1) !== 3'b100 || active_unit !== 2'd2) begin
            failures++;
            $display("FAIL orphan_armed orph=%b led2=%b au=%0d want orph=1 led2=100 au=2",
                     orph_k, led(1), active_unit);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pulse(C_RU);
        pulse(C_FD | C_OD);
        checks++;
        if (led(2) !== 3'b001 || orph_k !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle led3=%b orph=%b want led3=001 orph=0", led(2), orph_k);
        end
        pulse(C_OD);
        checks++;
        if (led(2) !== 3'b010 || active_unit !== 2'd0 || orph_k !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_drop led3=%b au=%0d orph=%b want 010 au=0 orph=0",
                     led(2), active_unit, orph_k);
        end
    endtask

    task automatic test_end_of_run();
        logic [8:0] exp;
        do_reset();
        pulse(C_EU);
        pulse(C_FD);
        stim[5] = 1'b1;
        step();
        step();
        // Events injected mid-blink must be ignored without orphan pulses.
        for (int j = 0; j < 4 * BC; j++) begin
            exp = (((j / BC) % 2) == 0) ? 9'b010_010_010 : 9'b0;
            checks++;
            if ({led(0), led(1), led(2)} !== exp || orphan_event !== 1'b0 || active_unit !== 2'd1) begin
                failures++;
                $display("FAIL blink j=%0d leds=%b orph=%b au=%0d want leds=%b orph=0 au=1",
                         j, {led(0), led(1), led(2)}, orphan_event, active_unit, exp);
            end
            case (j)
                1:  stim = stim | C_OD;
                2:  stim = stim & ~C_OD;
                5:  stim = stim | C_FD;
                6:  stim = stim & ~C_FD;
                9:  stim = stim | C_CU;
                10: stim = stim & ~C_CU;
                default: ;
            endcase
            step();
        end
    endtask

    task automatic test_reset_mid_blink();
        reset = 1'b1;
        step();
        check_all_zero("reset_mid_blink");
        step();
        reset = 1'b0;
        step();
        check_all_zero("reset_release_first_edge");
        step();
        checks++;
        if ({led(0), led(1), led(2)} !== 9'b010_010_010) begin
            failures++;
            $display("FAIL rerun_green leds=%b want 010010010", {led(0), led(1), led(2)});
        end
        stim[5] = 1'b0;
    endtask

    task automatic test_reset_mid_lifecycle();
        do_reset();
        pulse(C_CU);
        pulse(C_FD);
        checks++;
        if (led(1) !== 3'b001 || active_unit !== 2'd2) begin
            failures++;
            $display("FAIL lifecycle_pre led2=%b au=%0d want 001 au=2", led(1), active_unit);
        end
        reset = 1'b1;
        step();
        check_all_zero("reset_mid_lifecycle");
        reset = 1'b0;
        step();
        step();
        check_all_zero("post_reset_cleared");
    endtask

    initial begin
        orph_k = 1'b0;
        test_reset();
        test_single_lifecycle();
        test_simultaneous_arming();
        test_orphans();
        test_same_cycle();
        test_end_of_run();
        test_reset_mid_blink();
        test_reset_mid_lifecycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_status_scheduler.md
# led_status_scheduler

Sequencing controller for the three on-board RGB status LEDs. It tracks a fault lifecycle for each of the three fault units (EU, CU, RU) and keeps them in an arrival-order queue. The shared `fault_detect` and `object_drop` events are attributed to the oldest unresolved unit. At end of run it takes over all LEDs for a green blink. It sits between the navigation/pick-and-place control logic and the LED pins.

## Interface
- `BLINK_CYCLES`, default 50_000_000: clk_50M cycles per blink half-period (1 s); minimum 2.
- `clk_50M`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `EU_fault_flag`, `CU_fault_flag`, `RU_fault_flag`  in  1 each  level inputs; a rising edge arms that unit.
- `fault_detect`  in  1  level input; a rising edge means the fault was located.
- `object_drop`  in  1  level input; a rising edge means the fault was rectified.
- `run_complete`  in  1  level input; a rising edge enters end-of-run mode.
- `led1_R1 led1_G1 led1_B1`  out  1 each  LED1 colour; owned by EU.
- `led2_R2 led2_G2 led2_B2`  out  1 each  LED2 colour; owned by CU.
- `led3_R3 led3_G3 led3_B3`  out  1 each  LED3 colour; owned by RU.
- `active_unit`  out  2  head of the queue: 0 = none, 1 = EU, 2 = CU, 3 = RU.
- `orphan_event`  out  1  one-cycle pulse when a detect or drop edge cannot be attributed to any unit.

## Operation
- **Edge detection.** Every input is registered once. A rise is defined as current sample = 1 and previous sample = 0. The previous-sample registers reset to 0, so an input held high through reset produces a rise on the first cycle after reset.
- **Per-unit FSM.** Each unit has its own FSM with states IDLE, ARMED, DETECTED, RECTIFIED.
  - IDLE→ARMED on a rise of that unit's fault flag; the unit's ID is pushed to the queue tail.
  - ARMED→DETECTED on a `fault_detect` rise, only while the unit is the queue head.
  - DETECTED→RECTIFIED on an `object_drop` rise, only while the unit is the queue head; the head is popped in the same cycle.
  - RECTIFIED is terminal until reset.
  - A fault flag rise for a unit not in IDLE is ignored. Each unit can be armed once per run.
- **Queue.** Depth 3, 2-bit IDs, FIFO order. Overflow is impossible because each unit is pushed at most once.
  - Simultaneous arming rises push in the fixed order EU, CU, RU.
  - A push and a pop in the same cycle are both applied; the new head is evaluated after the pop.
- **Event attribution.**
  - `fault_detect` rise with the head in ARMED: advances the head.
  - `fault_detect` rise with the head in DETECTED: ignored, no orphan pulse.
  - `fault_detect` rise with the queue empty: `orphan_event` pulse.
  - `object_drop` rise with the head in DETECTED: advances and pops the head.
  - `object_drop` rise with the head in ARMED, or with the queue empty: `orphan_event` pulse, no state change.
  - When a `fault_detect` rise and an `object_drop` rise land in the same cycle, only `fault_detect` is processed; the drop is ignored with no orphan pulse.
- **LED colour per unit, as {R,G,B}:** IDLE 000, ARMED 100, DETECTED 001, RECTIFIED 010.
- **End-of-run mode.**
  - A `run_complete` rise enters RUN_DONE, regardless of the unit states. Unit FSMs and the queue freeze, and all later event rises are ignored with no orphan pulses.
  - In RUN_DONE all three LEDs show 010 in the on phase and 000 in the off phase.
  - The phase starts at on, and the blink counter clears on entry.
  - The counter counts 0..BLINK_CYCLES-1. At BLINK_CYCLES-1 the phase toggles and the counter wraps to 0.
  - RUN_DONE is left only by `reset`.
- **Reset values.**
  - All LED outputs 0, `active_unit` 0, `orphan_event` 0.
  - All FSMs IDLE, queue empty, blink counter 0, phase on, not in RUN_DONE.
  - Reset asserted mid-blink or mid-lifecycle clears everything on that edge.

## Timing
- An input sampled high at edge k, with a previous sample of 0, changes FSM, queue and mode state at edge k.
- LED outputs and `active_unit` are registered from that state and update at edge k+1. Input rise to LED change is 2 edges from the first high sample.
- `orphan_event` is asserted for exactly the one cycle after edge k.
- In RUN_DONE entered at edge k:
  - LEDs show on-phase green from edge k+1.
  - The first toggle to off is visible BLINK_CYCLES edges after that.
  - Each phase lasts exactly BLINK_CYCLES cycles.
- While `reset` is high, outputs hold their reset values. The first input rise is accepted on the first edge at which `reset` is low.

## Test plan
All scenarios use BLINK_CYCLES = 4.
1. **Single-unit lifecycle.**
   - Stimulus: EU rise, then `fault_detect` rise, then `object_drop` rise.
   - Required response: LED1 goes 100 → 001 → 010; `active_unit` goes 1 → 1 → 0; LED2 and LED3 stay 000; no orphan pulse.
2. **Simultaneous arming.**
   - Stimulus: EU, CU and RU rise in the same cycle; then three `fault_detect`/`object_drop` pairs.
   - Required response: `active_unit` goes 1 → 2 → 3 → 0; each LED turns 001 and then 010 in EU, CU, RU order.
3. **Orphans.**
   - Stimulus: `object_drop` rise with the queue empty; then a CU rise followed by an `object_drop` rise before any `fault_detect`.
   - Required response: two single-cycle `orphan_event` pulses; LED2 stays 100.
4. **Same-cycle events.**
   - Stimulus: RU rise, then `fault_detect` and `object_drop` rising in the same cycle.
   - Required response: LED3 shows 001, not 010; no orphan pulse. A later `object_drop` rise makes LED3 010.
5. **End of run.**
   - Stimulus: with EU in DETECTED, a `run_complete` rise.
   - Required response: all LEDs show 010 for 4 cycles, 000 for 4 cycles, and repeat; subsequent `object_drop` and `fault_detect` rises cause no change and no orphan pulse.
6. **Reset.**
   - Stimulus: assert `reset` mid-blink, and again mid-lifecycle.
   - Required response: all outputs are 0 on the next edge; with `run_complete` still held high, a rise is re-detected after release and RUN_DONE is re-entered.
